// File: rtl/nn_mem_pkg.sv
// Shared constants and state encoding for the layer-2 bias memory path.
package nn_mem_pkg;

    localparam int BIAS_W      = 10;
    localparam int BIAS2_DEPTH = 10;
    localparam int BIAS_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        PUB
    } loader_state_t;

endpackage

// File: rtl/bias2_loader_if.sv
// Valid/ready stream carrying bias words from the download path into the loader.
interface bias2_loader_if
    import nn_mem_pkg::*;
#(
    parameter int DATA_W = BIAS_W
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/bias2_memory.sv
// Layer-2 bias memory: single write port plus a read strobe that publishes
// every entry on a parallel output bus. Contents are never cleared.
module bias2_memory
    import nn_mem_pkg::*;
#(
    parameter int DATA_W = BIAS_W,
    parameter int DEPTH  = BIAS2_DEPTH,
    parameter int ADDR_W = BIAS_ADDR_W
) (
    input  logic                         clk,
    input  logic [DATA_W-1:0]            datain,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         wt,
    input  logic                         rd,
    output logic [DEPTH-1:0][DATA_W-1:0] dataout
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_d, mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] dataout_d, dataout_q;

    // Next contents: write the addressed entry; publish the array on rd.
    always_comb begin
        mem_d     = mem_q;
        dataout_d = dataout_q;
        if (wt && (int'(addr) < DEPTH)) begin
            mem_d[addr] = datain;
        end
        if (rd) begin
            dataout_d = mem_q;
        end
    end

    // Storage and output latch registers.
    always_ff @(posedge clk) begin
        mem_q     <= mem_d;
        dataout_q <= dataout_d;
    end

    assign dataout = dataout_q;

endmodule

// File: rtl/bias2_loader.sv
// Write-side controller for the layer-2 bias memory: streams DEPTH words into
// addresses 0..DEPTH-1, then strobes a single read so the memory publishes
// all entries, then pulses done.
module bias2_loader
    import nn_mem_pkg::*;
#(
    parameter int DATA_W = BIAS_W,
    parameter int DEPTH  = BIAS2_DEPTH,
    parameter int ADDR_W = BIAS_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    bias2_loader_if.slave     in_if,
    output logic [DATA_W-1:0] mem_datain,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wt,
    output logic              mem_rd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    loader_state_t     state_d, state_q;
    logic [ADDR_W-1:0] count_d, count_q;
    logic [DATA_W-1:0] mem_datain_d, mem_datain_q;
    logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
    logic              mem_wt_d, mem_wt_q;
    logic              mem_rd_d, mem_rd_q;
    logic              done_d, done_q;

    // Next-state and registered-output logic; strobes default low each cycle.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mem_datain_d = mem_datain_q;
        mem_addr_d   = mem_addr_q;
        mem_wt_d     = 1'b0;
        mem_rd_d     = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                // in_ready is high for the whole of LOAD, so valid alone marks a transfer.
                if (in_if.in_valid) begin
                    mem_wt_d     = 1'b1;
                    mem_addr_d   = count_q;
                    mem_datain_d = in_if.in_data;
                    count_d      = count_q + ADDR_W'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // The final write is on the bus this cycle; rd follows it.
                mem_rd_d = 1'b1;
                state_d  = PUB;
            end
            PUB: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and memory-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            mem_datain_q <= '0;
            mem_addr_q   <= '0;
            mem_wt_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mem_datain_q <= mem_datain_d;
            mem_addr_q   <= mem_addr_d;
            mem_wt_q     <= mem_wt_d;
            mem_rd_q     <= mem_rd_d;
            done_q       <= done_d;
        end
    end

    assign in_if.in_ready = (state_q == LOAD);
    assign busy           = (state_q != IDLE);
    assign mem_datain     = mem_datain_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wt         = mem_wt_q;
    assign mem_rd         = mem_rd_q;
    assign done           = done_q;
    assign count          = count_q;

endmodule

// File: doc/bias2_loader.md
Name: bias2_loader

Overview:
- Write-side controller for the 10-entry layer-2 bias memory.
- Accepts bias words one at a time on a valid/ready stream and drives the memory's datain/addr/wt port to fill entries 0..DEPTH-1 in order.
- After the fill, issues a single read strobe so the memory publishes all entries on its parallel outputs, then pulses done.
- Sits between the weight/bias download path and the layer-2 bias memory.

Parameters:
- DATA_W, 10, bias word width; equals memory datain width.
- DEPTH, 10, number of bias entries to load.
- ADDR_W, 4, memory address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- in_valid  input  1  in_data holds a bias word.
- in_data  input  DATA_W  bias word for the current address.
- in_ready  output  1  loader accepts a word this cycle; high exactly when state==LOAD; combinational from state.
- mem_datain  output  DATA_W  to memory datain; registered.
- mem_addr  output  ADDR_W  to memory addr; registered.
- mem_wt  output  1  to memory wt; registered.
- mem_rd  output  1  to memory rd; registered.
- busy  output  1  high in LOAD, READ and PUB.
- done  output  1  one-cycle pulse when the load and publish are complete.
- count  output  ADDR_W  number of words accepted in the current load.

Behaviour:
- Reset (rst_n low at a clk edge), regardless of state:
  - state=IDLE; mem_datain=0, mem_addr=0, mem_wt=0, mem_rd=0, done=0, count=0.
  - A load in progress is abandoned. Memory contents are not cleared.
- States: IDLE, LOAD, READ, PUB.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD, count<=0.
- LOAD:
  - in_ready=1.
  - Transfer when in_valid & in_ready. Transfer at edge k gives mem_wt=1, mem_addr=count, mem_datain=in_data during cycle k+1. The memory writes at edge k+1.
  - count<=count+1 on each transfer.
  - No transfer: mem_wt<=0. in_data is ignored when in_valid=0.
  - Transfer with count==DEPTH-1 -> READ.
- READ:
  - One cycle. in_ready=0, so the last write completes with rd low.
  - Next edge: mem_wt<=0, mem_rd<=1 -> PUB.
- PUB:
  - mem_rd=1 and mem_wt=0 for this one cycle; the memory latches all outputs at the closing edge.
  - Next edge: mem_rd<=0, done<=1 -> IDLE.
- done:
  - High only in the first IDLE cycle after PUB.
  - Cleared the following edge.
- Timing: last word accepted at edge k -> last mem_wt cycle k+1, mem_rd cycle k+2, done cycle k+3.
- Invariants:
  - mem_wt and mem_rd are never high together.
  - mem_addr never exceeds DEPTH-1.
- start while busy is ignored. start in the done cycle begins a new load (count<=0).
- count holds DEPTH after completion until the next start or reset.
- in_valid stalls of any length are allowed in LOAD; state and count hold.
- No wrap-around: the loader never accepts more than DEPTH words per start.

Decomposition:
- Shared package nn_mem_pkg:
  - constants BIAS_W=10, BIAS2_DEPTH=10, BIAS_ADDR_W=4.
  - state enum typedef loader_state_t {IDLE, LOAD, READ, PUB}.
- No sub-module: one FSM plus a counter and output registers.
- Testbench instantiates bias2_loader driving bias2_memory for end-to-end checks.

Test Plan:
- Basic fill:
  - Stimulus: reset, start, then words 10'd1..10'd10 with in_valid held high.
  - Response: mem_wt high 10 consecutive cycles with addr 0..9; mem_rd one cycle 2 cycles after last accept; done 3 cycles after; memory dataout0..9 = 1..10.
- Stalled stream:
  - Stimulus: same words, in_valid low 3 cycles between each.
  - Response: exactly 10 mem_wt pulses, no write during stalls, count steps 0..10, same final dataouts.
- start while busy:
  - Stimulus: pulse start during LOAD at count=4.
  - Response: count continues 5..10; no restart; one done pulse.
- Reset mid-load:
  - Stimulus: rst_n low for one edge at count=6.
  - Response: next cycle IDLE, all outputs 0, in_ready=0.
  - Follow-up: a new start with 10 words of 10'h3FF gives all dataouts 10'h3FF and count=10.
- Back-to-back loads:
  - Stimulus: start asserted in the done cycle, words 10'd100..10'd109.
  - Response: second load begins with mem_addr=0; mem_rd and mem_wt never overlap; dataout9=109.
- Exclusivity check:
  - Stimulus: random valid gaps over 50 loads.
  - Response: an assertion shows mem_wt & mem_rd never both 1, and mem_addr < 10 whenever mem_wt=1.
